// File: rtl/hex_keypad_scanner_pkg.sv
// Shared keypad definitions: scanner FSM states, {row,col} keymap and the
// active-low column strobe encoding (also used by the display select decoder).
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2
   } scan_state_t;

   // Indexed by {row, col}; '*' reads as E and '#' as F.
   localparam logic [15:0][3:0] KEYMAP = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   localparam logic [3:0][3:0] COL_STROBE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   // Lowest-numbered low row wins when several rows are pulled down.
   function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/hex_keypad_scanner_if.sv
// Keypad-side and entry-side signals of the hex keypad scanner.
interface hex_keypad_scanner_if;
   logic [3:0]  row;
   logic        clr;
   logic [3:0]  col;
   logic [3:0]  key;
   logic        key_valid;
   logic        key_held;
   logic [15:0] value;

   modport master (input row, clr, output col, key, key_valid, key_held, value);
   modport slave  (output row, clr, input col, key, key_valid, key_held, value);
endinterface

// File: rtl/hex_keypad_scanner_scan_tick_gen.sv
// Free-running divider: one-cycle tick every clkdiv_ratio+1 clocks.
module scan_tick_gen #(
   parameter int unsigned clkdiv_ratio = 100
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int unsigned DIV_W = (clkdiv_ratio > 0) ? $clog2(clkdiv_ratio + 1) : 1;

   logic [DIV_W-1:0] div_q, div_d;

   assign tick = (div_q == DIV_W'(clkdiv_ratio));

   always_comb begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) div_q <= '0;
      else     div_q <= div_d;
   end
endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: strobes columns, debounces press and release on scan
// ticks, and shifts each accepted key code into a 4-digit entry register.
module hex_keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned clkdiv_ratio   = 100,
   parameter int unsigned debounce_ticks = 4
) (
   input logic                  clk,
   input logic                  rst,
   hex_keypad_scanner_if.master kp
);
   localparam int unsigned CNT_W = $clog2(debounce_ticks + 1);

   logic             tick;
   logic [3:0]       sync1_q, rs_q;
   scan_state_t      state_q, state_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [1:0]       row_q, row_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0]       key_q, key_d, code;
   logic             key_valid_q, key_valid_d;
   logic             key_held_q, key_held_d;
   logic [15:0]      value_q, value_d;
   logic             accept, row_low;

   scan_tick_gen #(.clkdiv_ratio(clkdiv_ratio)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign row_low = !rs_q[row_q];
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      col_idx_d  = col_idx_q;
      row_d      = row_q;
      cnt_d      = cnt_q;
      key_held_d = key_held_q;
      accept     = 1'b0;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (rs_q != 4'hF) begin
                  // Column stays frozen until the key is released or rejected.
                  row_d = lowest_low_row(rs_q);
                  if (debounce_ticks <= 1) begin
                     accept  = 1'b1;
                     state_d = PRESSED;
                     cnt_d   = '0;
                  end else begin
                     cnt_d   = CNT_W'(1);
                     state_d = DEBOUNCE;
                  end
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (!row_low) begin
                  state_d   = SCAN;
                  col_idx_d = col_idx_q + 2'd1;
                  cnt_d     = '0;
               end else if (cnt_inc == CNT_W'(debounce_ticks)) begin
                  accept  = 1'b1;
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            PRESSED: begin
               if (row_low) begin
                  cnt_d = '0;
               end else if (cnt_inc == CNT_W'(debounce_ticks)) begin
                  key_held_d = 1'b0;
                  state_d    = SCAN;
                  col_idx_d  = col_idx_q + 2'd1;
                  cnt_d      = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: state_d = SCAN;
         endcase
      end

      code        = KEYMAP[{row_d, col_idx_q}];
      key_valid_d = accept;
      key_d       = accept ? code : key_q;
      if (accept) key_held_d = 1'b1;
      // A coincident clear beats the shift-in.
      if (kp.clr)      value_d = '0;
      else if (accept) value_d = {value_q[11:0], code};
      else             value_d = value_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 4'hF;
         rs_q        <= 4'hF;
         state_q     <= SCAN;
         col_idx_q   <= 2'd0;
         row_q       <= 2'd0;
         cnt_q       <= '0;
         key_q       <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         value_q     <= 16'h0000;
      end else begin
         sync1_q     <= kp.row;
         rs_q        <= sync1_q;
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         value_q     <= value_d;
      end
   end

   assign kp.col       = COL_STROBE[col_idx_q];
   assign kp.key       = key_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;
   assign kp.value     = value_q;
endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Self-checking bench: keypad matrix model driving rows from the strobed
// column, checked against a tick/period-level model of scanning and entry.
module tb_hex_keypad_scanner;
   localparam int DT = 3;   // debounce ticks; tick period is 4 clocks

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   cyc;
   int   kv_count;
   logic [15:0] model_value;
   logic [3:0]  mat [4];    // mat[r][c] = key at row r, column c is down

   // Keymap as printed on the keypad, row by row.
   logic [3:0] km [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   hex_keypad_scanner_if kp();

   hex_keypad_scanner #(.clkdiv_ratio(3), .debounce_ticks(DT)) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp)
   );

   // A row reads low when any pressed key in it sits on the strobed column.
   assign kp.row = {~|(mat[3] & ~kp.col), ~|(mat[2] & ~kp.col),
                    ~|(mat[1] & ~kp.col), ~|(mat[0] & ~kp.col)};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= rst ? 0 : cyc + 1;
      if (kp.key_valid) kv_count <= kv_count + 1;
   end

   function automatic logic [3:0] col_exp(input int i);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << i);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step_to(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_col", kp.col, 4'b1110);
      check_eq("rst_key", kp.key, 0);
      check_eq("rst_kv", kp.key_valid, 0);
      check_eq("rst_held", kp.key_held, 0);
      check_eq("rst_value", kp.value, 0);
      model_value = 16'h0000;
      rst = 1'b0;
   endtask

   task automatic wait_accept(input logic [3:0] code);
      int n;
      n = 0;
      while (kp.key_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("accept_seen", kp.key_valid, 1);
      model_value = {model_value[11:0], code};
      check_eq("key", kp.key, code);
      check_eq("value", kp.value, model_value);
      check_eq("held_on_accept", kp.key_held, 1);
      $display("key %h accepted at cycle %0d, value %h", kp.key, cyc, kp.value);
   endtask

   // Release is seen by the first tick at least 3 clocks later (2-flop sync);
   // key_held drops at the DT-th high tick, and scanning moves to column c+1.
   task automatic release_check(input int r, input int c);
      int k_rel;
      mat[r][c] = 1'b0;
      k_rel = ((cyc + 6) / 4) * 4 + 4 * (DT - 1);
      step_to(k_rel - 1);
      check_eq("held_before_release", kp.key_held, 1);
      @(negedge clk);
      check_eq("held_after_release", kp.key_held, 0);
      check_eq("col_after_release", kp.col, col_exp((c + 1) % 4));
   endtask

   task automatic press_release(input int r, input int c, input int hold);
      int base;
      base = kv_count;
      mat[r][c] = 1'b1;
      wait_accept(km[r][c]);
      repeat (hold) @(negedge clk);
      check_eq("single_pulse", kv_count - base, 1);
      check_eq("held_during", kp.key_held, 1);
      release_check(r, c);
   endtask

   initial begin
      int base, t0, r, c;
      n_checks = 0;
      n_errors = 0;
      kv_count = 0;
      cyc      = 0;
      rst      = 1'b1;
      kp.clr   = 1'b0;
      for (int i = 0; i < 4; i++) mat[i] = 4'h0;

      // Idle scan: column advances every 4 clocks, no key activity.
      do_reset();
      base = kv_count;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         check_eq("idle_col", kp.col, col_exp((k / 4) % 4));
      end
      check_eq("idle_no_kv", kv_count - base, 0);

      // Rows 1 and 2 on column 0 held through reset: row 1 wins, accepted
      // at the third stable tick (clock 12).
      mat[1][0] = 1'b1;
      mat[2][0] = 1'b1;
      do_reset();
      step_to(11);
      check_eq("latency_kv_early", kp.key_valid, 0);
      @(negedge clk);
      check_eq("latency_kv", kp.key_valid, 1);
      check_eq("multi_row_key", kp.key, 4'h4);
      check_eq("multi_row_value", kp.value, 16'h0004);
      @(negedge clk);
      check_eq("kv_one_cycle", kp.key_valid, 0);
      model_value = 16'h0004;
      repeat (10) @(negedge clk);
      mat[2][0] = 1'b0;
      release_check(1, 0);

      // Clean press of "6", held 40 clocks; scanning resumes at column 3.
      do_reset();
      press_release(1, 2, 40);

      // "1","2","3","A","5" shifted in; oldest digit falls off.
      do_reset();
      base = kv_count;
      press_release(0, 0, 12);
      press_release(0, 1, 12);
      press_release(0, 2, 12);
      press_release(0, 3, 12);
      press_release(1, 1, 12);
      check_eq("seq_value", kp.value, 16'h23A5);
      check_eq("seq_pulses", kv_count - base, 5);
      kp.clr = 1'b1;
      @(negedge clk);
      kp.clr = 1'b0;
      check_eq("clr_value", kp.value, 0);
      model_value = 16'h0000;

      // Random keys with random gaps and hold times.
      for (int n = 0; n < 8; n++) begin
         r = $urandom_range(3);
         c = $urandom_range(3);
         repeat ($urandom_range(10)) @(negedge clk);
         press_release(r, c, $urandom_range(50, 10));
      end

      // Bounce: low for one tick then high; press rejected, scan continues.
      mat[0][0] = 1'b1;
      do_reset();
      base = kv_count;
      step_to(4);
      mat[0][0] = 1'b0;
      step_to(7);
      check_eq("bounce_col_frozen", kp.col, 4'b1110);
      step_to(8);
      check_eq("bounce_col_adv", kp.col, 4'b1101);
      check_eq("bounce_held", kp.key_held, 0);
      step_to(12);
      check_eq("bounce_col_scan", kp.col, 4'b1011);
      check_eq("bounce_no_kv", kv_count - base, 0);

      // "#" held, "D" pressed on the same row: D waits for # release.
      do_reset();
      base = kv_count;
      mat[3][2] = 1'b1;
      wait_accept(4'hF);
      mat[3][3] = 1'b1;
      repeat (60) @(negedge clk);
      check_eq("lockout_pulses", kv_count - base, 1);
      check_eq("lockout_key", kp.key, 4'hF);
      release_check(3, 2);
      wait_accept(4'hD);
      repeat (5) @(negedge clk);
      check_eq("after_lockout_pulses", kv_count - base, 2);
      release_check(3, 3);

      // Reset while debouncing aborts the press.
      mat[0][0] = 1'b1;
      do_reset();
      base = kv_count;
      step_to(6);
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_col", kp.col, 4'b1110);
      check_eq("midrst_kv", kp.key_valid, 0);
      mat[0][0] = 1'b0;
      do_reset();
      repeat (30) @(negedge clk);
      check_eq("midrst_no_kv", kv_count - base, 0);

      // clr in the acceptance cycle: value cleared, key still updates.
      do_reset();
      press_release(2, 0, 8);
      t0 = cyc;
      mat[0][1] = 1'b1;
      step_to(t0 + 11);
      check_eq("pre_clr_value", kp.value, model_value);
      check_eq("pre_clr_kv", kp.key_valid, 0);
      kp.clr = 1'b1;
      @(negedge clk);
      kp.clr = 1'b0;
      check_eq("clr_acc_kv", kp.key_valid, 1);
      check_eq("clr_acc_key", kp.key, 4'h2);
      check_eq("clr_acc_value", kp.value, 0);
      @(negedge clk);
      check_eq("clr_acc_value_hold", kp.value, 0);
      release_check(0, 1);
      check_eq("key_retained", kp.key, 4'h2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
